// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg -- shared types and constants for the instruction-memory arbiter.
//   state_t : sequencer states (IDLE, ACCESS, RESP)
//   PORT_F  : id of the core fetch port
//   PORT_L  : id of the program-loader/debug port
//   WORD_W  : bank word width
//   ADDR_W  : word-address width on both requester ports and the bank
// ---------------------------------------------------------------------------
package imem_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 8;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_L = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 -- two-request round-robin picker.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, indexed by PORT_F / PORT_L
//   en         : grants may be issued this cycle
//   gnt[1:0]   : one-hot grant (all zero when en=0 or no request)
// The port granted last is remembered; on a tie the other port wins.
// After reset the loader counts as last, so fetch wins the first tie.
// ---------------------------------------------------------------------------
module rr_arb2
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last;

    // NOTE: every output of a combinational block gets a default first,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[PORT_F] && (!req[PORT_L] || last == PORT_L)) begin
                gnt[PORT_F] = 1'b1;
            end else if (req[PORT_L]) begin
                gnt[PORT_L] = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= PORT_L;
        end else if (|gnt) begin
            last <= gnt[PORT_L] ? PORT_L : PORT_F;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter -- shares the instruction-memory bank between the core fetch
// port and the loader/debug port, one access at a time.
//   Parameters : DEPTH   number of valid words (addresses >= DEPTH error out)
//                MEM_LAT cycles the bank lines are held (1..7)
//   Fetch port : f_req, f_addr  -> f_gnt, f_rsp, f_rdata, f_err
//   Loader port: l_req, l_we, l_addr, l_wdata -> l_gnt, l_rsp, l_rdata, l_err
//   Bank       : mem_read, mem_write, mem_addr, mem_wdata  <- mem_rdata
// Grant is combinational in IDLE; an in-range access spends MEM_LAT cycles
// in ACCESS, an out-of-range one goes straight to RESP with err=1. The RESP
// cycle pulses x_rsp for the granted port; x_rdata/x_err hold until that
// port's next response.
// ---------------------------------------------------------------------------
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rsp,
    output logic [WORD_W-1:0] f_rdata,
    output logic              f_err,

    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [WORD_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rsp,
    output logic [WORD_W-1:0] l_rdata,
    output logic              l_err,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    state_t            state, state_nxt;
    logic [2:0]        cnt;
    logic              cur_port;
    logic              cur_we;

    logic [1:0]        gnt;
    logic              sel_l;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic              sel_in_range;
    logic              last_beat;

    logic              rsp_load;
    logic              rsp_port;
    logic [WORD_W-1:0] rsp_data;
    logic              rsp_err;

    // Gating with rst_n keeps the combinational grants at 0 while reset is held.
    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({l_req, f_req}),
        .en    ((state == IDLE) && rst_n),
        .gnt   (gnt)
    );

    assign f_gnt = gnt[PORT_F];
    assign l_gnt = gnt[PORT_L];

    // Request of whichever port wins this cycle.
    assign sel_l        = gnt[PORT_L];
    assign sel_addr     = sel_l ? l_addr : f_addr;
    assign sel_we       = sel_l & l_we;
    assign sel_in_range = int'(sel_addr) < DEPTH;
    assign last_beat    = (cnt == 3'(MEM_LAT - 1));

    // Next state plus the response-register load strobe.
    always_comb begin
        state_nxt = state;
        rsp_load  = 1'b0;
        rsp_port  = cur_port;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        case (state)
            IDLE: begin
                if (|gnt) begin
                    if (sel_in_range) begin
                        state_nxt = ACCESS;
                    end else begin
                        state_nxt = RESP;
                        rsp_load  = 1'b1;
                        rsp_port  = sel_l;
                        rsp_err   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (last_beat) begin
                    state_nxt = RESP;
                    rsp_load  = 1'b1;
                    rsp_data  = cur_we ? '0 : mem_rdata;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write strobe only on the first ACCESS beat; the remaining beats just
    // hold address/data steady for the bank.
    assign mem_read  = (state == ACCESS) && !cur_we;
    assign mem_write = (state == ACCESS) && cur_we && (cnt == 3'd0);
    assign f_rsp     = (state == RESP) && (cur_port == PORT_F);
    assign l_rsp     = (state == RESP) && (cur_port == PORT_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_port  <= PORT_F;
            cur_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_rdata   <= '0;
            f_err     <= 1'b0;
            l_rdata   <= '0;
            l_err     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && (|gnt)) begin
                cur_port <= sel_l;
                cur_we   <= sel_we;
                cnt      <= '0;
                // Bank lines move only for a real access; otherwise they hold.
                if (sel_in_range) begin
                    mem_addr <= sel_addr;
                    if (sel_we) begin
                        mem_wdata <= l_wdata;
                    end
                end
            end else if (state == ACCESS) begin
                cnt <= cnt + 3'd1;
            end

            if (rsp_load) begin
                if (rsp_port == PORT_L) begin
                    l_rdata <= rsp_data;
                    l_err   <= rsp_err;
                end else begin
                    f_rdata <= rsp_data;
                    f_err   <= rsp_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter -- bench for imem_arbiter. Main instance uses MEM_LAT=1
// with a bank model (synchronous write, combinational read); a second
// instance uses MEM_LAT=3 with bank data driven directly by the bench.
// ---------------------------------------------------------------------------
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int LAT = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        f_req, l_req, l_we;
    logic [7:0]  f_addr, l_addr;
    logic [31:0] l_wdata;
    logic        f_gnt, f_rsp, f_err, l_gnt, l_rsp, l_err, mem_read, mem_write;
    logic [31:0] f_rdata, l_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;

    // MEM_LAT=3 instance
    logic        f_req3;
    logic [7:0]  f_addr3;
    logic [31:0] mem_rdata3;
    logic        f_gnt3, f_rsp3, f_err3, l_gnt3, l_rsp3, l_err3, mem_read3, mem_write3;
    logic [31:0] f_rdata3, l_rdata3, mem_wdata3;
    logic [7:0]  mem_addr3;

    int n_tests = 0;
    int n_fail  = 0;

    imem_arbiter #(.DEPTH(64), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rsp(f_rsp),
        .f_rdata(f_rdata), .f_err(f_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rsp(l_rsp), .l_rdata(l_rdata), .l_err(l_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    imem_arbiter #(.DEPTH(64), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_rsp(f_rsp3),
        .f_rdata(f_rdata3), .f_err(f_err3),
        .l_req(1'b0), .l_we(1'b0), .l_addr(8'd0), .l_wdata(32'd0),
        .l_gnt(l_gnt3), .l_rsp(l_rsp3), .l_rdata(l_rdata3), .l_err(l_err3),
        .mem_read(mem_read3), .mem_write(mem_write3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 3) ? 32'h1F60_0001 : 32'hA500_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // Bank model: reloaded on reset, synchronous write, combinational read.
    logic [31:0] bank [64];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) bank[i] <= init_word(i);
        end else if (mem_write) begin
            bank[mem_addr[5:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = bank[mem_addr[5:0]];

    task automatic apply_reset();
        f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
        f_req3 = 0; f_addr3 = 0; mem_rdata3 = 0;
        @(negedge clk); rst_n = 0;
        @(negedge clk); @(negedge clk); rst_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk); rst_n = 0; f_req = 1; l_req = 1; f_addr = 5; l_addr = 6;
        #1;
        n_tests++;
        if ({f_gnt, f_rsp, f_rdata, f_err, l_gnt, l_rsp, l_rdata, l_err,
             mem_read, mem_write, mem_addr, mem_wdata} !== 112'd0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        n_tests++;
        if ({f_gnt3, f_rsp3, f_rdata3, f_err3, l_gnt3, l_rsp3, l_rdata3, l_err3,
             mem_read3, mem_write3, mem_addr3, mem_wdata3} !== 112'd0) begin
            n_fail++; $display("FAIL reset_outputs_lat3: got nonzero outputs, required all 0");
        end
        @(negedge clk); rst_n = 1; #1;
        n_tests++;
        if ({f_gnt, l_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL first_tie: gnt f/l=%b, required 10", {f_gnt, l_gnt});
        end
        @(negedge clk); f_req = 0; l_req = 0;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_fetch_read();
        apply_reset();
        f_req = 1; f_addr = 3; #1;
        n_tests++;
        if ({f_gnt, l_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL fetch_gnt: gnt f/l=%b, required 10", {f_gnt, l_gnt});
        end
        @(negedge clk); f_req = 0;
        n_tests++;
        if ({mem_read, mem_write, mem_addr, f_rsp} !== {1'b1, 1'b0, 8'd3, 1'b0}) begin
            n_fail++; $display("FAIL fetch_access: rd=%b wr=%b addr=%0d rsp=%b, required 1 0 3 0",
                               mem_read, mem_write, mem_addr, f_rsp);
        end
        @(negedge clk);
        n_tests++;
        if ({f_rsp, f_err, f_rdata, l_rsp, mem_read} !== {1'b1, 1'b0, 32'h1F60_0001, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL fetch_rsp: rsp=%b err=%b data=%h l_rsp=%b, required 1 0 1f600001 0",
                               f_rsp, f_err, f_rdata, l_rsp);
        end
        @(negedge clk);
        n_tests++;
        if ({f_rsp, f_rdata} !== {1'b0, 32'h1F60_0001}) begin
            n_fail++; $display("FAIL fetch_hold: rsp=%b data=%h, required 0 1f600001", f_rsp, f_rdata);
        end
    endtask

    task automatic test_write_readback();
        l_req = 1; l_we = 1; l_addr = 10; l_wdata = 32'hDEAD_BEEF; #1;
        n_tests++;
        if ({f_gnt, l_gnt} !== 2'b01) begin
            n_fail++; $display("FAIL write_gnt: gnt f/l=%b, required 01", {f_gnt, l_gnt});
        end
        @(negedge clk); l_req = 0; l_we = 0;
        n_tests++;
        if ({mem_write, mem_read, mem_addr, mem_wdata} !== {1'b1, 1'b0, 8'd10, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL write_access: wr=%b rd=%b addr=%0d wdata=%h, required 1 0 10 deadbeef",
                               mem_write, mem_read, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_tests++;
        if ({mem_write, l_rsp, l_err, l_rdata, f_rsp} !== {1'b0, 1'b1, 1'b0, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL write_rsp: wr=%b rsp=%b err=%b data=%h f_rsp=%b, required 0 1 0 0 0",
                               mem_write, l_rsp, l_err, l_rdata, f_rsp);
        end
        @(negedge clk); f_req = 1; f_addr = 10; #1;
        n_tests++;
        if ({f_gnt, l_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL readback_gnt: gnt f/l=%b, required 10", {f_gnt, l_gnt});
        end
        @(negedge clk); f_req = 0;
        @(negedge clk);
        n_tests++;
        if ({f_rsp, f_rdata, f_err} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            n_fail++; $display("FAIL readback_rsp: rsp=%b data=%h err=%b, required 1 deadbeef 0",
                               f_rsp, f_rdata, f_err);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [3:0] exp;
        apply_reset();
        f_req = 1; f_addr = 5; l_req = 1; l_we = 0; l_addr = 7;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp = {c % 6 == 0, c % 6 == 3, c % 6 == 2, c % 6 == 5};
            n_tests++;
            if ({f_gnt, l_gnt, f_rsp, l_rsp} !== exp) begin
                n_fail++; $display("FAIL contention_c%0d: gnt/rsp f,l=%b, required %b",
                                   c, {f_gnt, l_gnt, f_rsp, l_rsp}, exp);
            end
            if (c % 6 == 2 && f_rdata !== init_word(5)) begin
                n_fail++; $display("FAIL contention_fdata_c%0d: got %h, required %h", c, f_rdata, init_word(5));
            end
            if (c % 6 == 5 && l_rdata !== init_word(7)) begin
                n_fail++; $display("FAIL contention_ldata_c%0d: got %h, required %h", c, l_rdata, init_word(7));
            end
        end
        @(negedge clk); f_req = 0; l_req = 0;
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        l_req = 1; l_we = 0; l_addr = 8'd64; #1;
        n_tests++;
        if ({l_gnt, f_gnt, mem_read, mem_write} !== 4'b1000) begin
            n_fail++; $display("FAIL oor_gnt: l_gnt,f_gnt,rd,wr=%b, required 1000",
                               {l_gnt, f_gnt, mem_read, mem_write});
        end
        @(negedge clk); l_req = 0;
        n_tests++;
        if ({l_rsp, l_err, l_rdata, mem_read, mem_write, f_rsp} !== {1'b1, 1'b1, 32'd0, 3'b000}) begin
            n_fail++; $display("FAIL oor_rsp: rsp=%b err=%b data=%h rd=%b wr=%b, required 1 1 0 0 0",
                               l_rsp, l_err, l_rdata, mem_read, mem_write);
        end
        @(negedge clk);
        n_tests++;
        if ({l_rsp, l_err, mem_read, mem_write} !== 4'b0100) begin
            n_fail++; $display("FAIL oor_after: rsp,err,rd,wr=%b, required 0100",
                               {l_rsp, l_err, mem_read, mem_write});
        end
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        f_req = 1; f_addr = 4; #1;
        @(negedge clk); f_req = 0; l_req = 1; l_addr = 9; l_we = 0; #1;
        n_tests++;
        if (mem_read !== 1'b1) begin
            n_fail++; $display("FAIL mid_access_pre: mem_read=%b, required 1", mem_read);
        end
        rst_n = 0; #1;
        n_tests++;
        if ({f_gnt, f_rsp, f_rdata, f_err, l_gnt, l_rsp, l_rdata, l_err,
             mem_read, mem_write, mem_addr, mem_wdata} !== 112'd0) begin
            n_fail++; $display("FAIL mid_access_reset: outputs nonzero (rd=%b addr=%0d), required all 0",
                               mem_read, mem_addr);
        end
        @(negedge clk); rst_n = 1; f_req = 1; f_addr = 2; #1;
        n_tests++;
        if ({f_gnt, l_gnt, f_rsp, l_rsp} !== 4'b1000) begin
            n_fail++; $display("FAIL tie_after_reset: gnt/rsp f,l=%b, required 1000",
                               {f_gnt, l_gnt, f_rsp, l_rsp});
        end
        @(negedge clk); f_req = 0;
        n_tests++;
        if ({f_rsp, l_rsp} !== 2'b00) begin
            n_fail++; $display("FAIL stale_rsp: rsp f,l=%b, required 00", {f_rsp, l_rsp});
        end
        @(negedge clk); l_req = 0;
        n_tests++;
        if ({f_rsp, l_rsp, f_rdata} !== {2'b10, init_word(2)}) begin
            n_fail++; $display("FAIL post_reset_rsp: rsp f,l=%b data=%h, required 10 %h",
                               {f_rsp, l_rsp}, f_rdata, init_word(2));
        end
        @(negedge clk);
    endtask

    task automatic test_mem_lat3();
        apply_reset();
        f_req3 = 1; f_addr3 = 0; #1;
        n_tests++;
        if (f_gnt3 !== 1'b1) begin
            n_fail++; $display("FAIL lat3_gnt: got %b, required 1", f_gnt3);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); f_req3 = 0; mem_rdata3 = 32'hC0DE_0000 + 32'(c); #1;
            n_tests++;
            if ({mem_read3, mem_write3, mem_addr3, f_rsp3, l_rsp3} !== {1'b1, 1'b0, 8'd0, 2'b00}) begin
                n_fail++; $display("FAIL lat3_access_c%0d: rd=%b wr=%b addr=%0d rsp=%b, required 1 0 0 0",
                                   c, mem_read3, mem_write3, mem_addr3, f_rsp3);
            end
        end
        @(negedge clk); mem_rdata3 = 32'h0BAD_0BAD; #1;
        n_tests++;
        if ({mem_read3, f_rsp3, f_err3, f_rdata3} !== {1'b0, 1'b1, 1'b0, 32'hC0DE_0003}) begin
            n_fail++; $display("FAIL lat3_rsp: rd=%b rsp=%b err=%b data=%h, required 0 1 0 c0de0003",
                               mem_read3, f_rsp3, f_err3, f_rdata3);
        end
        @(negedge clk);
    endtask

    // Transaction-level reference: round-robin by last winner, fixed latency
    // per outcome, word-array memory, per-port held response values.
    task automatic test_random();
        logic [31:0] ref_mem [64];
        logic        f_act, l_act, win_l, last_l, we, inr, e;
        logic [7:0]  fa, la, a;
        logic        lwe;
        logic [31:0] lwd, r;
        logic [31:0] ef_d, el_d;
        logic        ef_e, el_e;
        int          lat;
        apply_reset();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        f_act = 0; l_act = 0; last_l = 1; fa = 0; la = 0; lwe = 0; lwd = 0;
        ef_d = 0; el_d = 0; ef_e = 0; el_e = 0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            if (!f_act && $urandom_range(0, 1) == 1) begin
                f_act = 1;
                fa = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(63, 255)) : 8'($urandom_range(0, 15));
            end
            if (!l_act && ($urandom_range(0, 1) == 1 || !f_act)) begin
                l_act = 1; lwe = 1'($urandom_range(0, 1)); lwd = $urandom;
                la = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(63, 255)) : 8'($urandom_range(0, 15));
            end
            f_req = f_act; f_addr = fa; l_req = l_act; l_addr = la; l_we = lwe; l_wdata = lwd;
            #1;
            win_l = (f_act && l_act) ? !last_l : l_act;
            n_tests++;
            if ({f_gnt, l_gnt} !== {!win_l, win_l}) begin
                n_fail++; $display("FAIL rand_gnt_t%0d: gnt f/l=%b, required %b", t, {f_gnt, l_gnt}, {!win_l, win_l});
            end
            last_l = win_l;
            a   = win_l ? la : fa;
            we  = win_l && lwe;
            inr = a < 8'd64;
            e   = !inr;
            r   = (!inr || we) ? 32'd0 : ref_mem[a[5:0]];
            if (inr && we) ref_mem[a[5:0]] = lwd;
            if (win_l) l_act = 0; else f_act = 0;
            lat = inr ? LAT + 1 : 1;
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                if (win_l) l_req = 0; else f_req = 0;
                #1;
                n_tests++;
                if ({f_gnt, l_gnt, mem_read, mem_write, f_rsp, l_rsp} !==
                    {2'b00, inr && !we && c <= LAT, inr && we && c == 1,
                     c == lat && !win_l, c == lat && win_l}) begin
                    n_fail++; $display("FAIL rand_seq_t%0d_c%0d: gnt,rd,wr,rsp=%b%b%b%b%b%b addr=%0d",
                                       t, c, f_gnt, l_gnt, mem_read, mem_write, f_rsp, l_rsp, a);
                end
                if (c == lat) begin
                    if (win_l) begin el_d = r; el_e = e; end else begin ef_d = r; ef_e = e; end
                    n_tests++;
                    if ({f_rdata, f_err, l_rdata, l_err} !== {ef_d, ef_e, el_d, el_e}) begin
                        n_fail++; $display("FAIL rand_data_t%0d: f=%h/%b l=%h/%b, required f=%h/%b l=%h/%b",
                                           t, f_rdata, f_err, l_rdata, l_err, ef_d, ef_e, el_d, el_e);
                    end
                end
            end
        end
        f_req = 0; l_req = 0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch_read();
        test_write_readback();
        test_contention();
        test_out_of_range();
        test_reset_mid_access();
        test_mem_lat3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
